// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter and its baud generator.
package uart_tx_cfg_pkg;

  function automatic int unsigned CeilLog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p * 2) r = r + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_mode_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: bit_tick marks the last clock of each serial bit; clear restarts the bit.
module uart_baud_gen
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  // A one-clock bit still needs a 1-bit counter to declare.
  localparam int unsigned CW = (CeilLog2(CLKS_PER_BIT) == 0) ? 1 : CeilLog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, LSB-first data, optional parity, one or two stop bits,
// with run-time parity/stop selection latched on each accepted request.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned WORD_LENGHT  = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGHT-1:0] Tx_in,
  input  logic                   send,
  input  logic [1:0]             parity_mode,
  input  logic                   two_stop,
  output logic                   Tx_out,
  output logic                   Tx_ready
);

  localparam int unsigned IW = CeilLog2(WORD_LENGHT);

  tx_state_t              state, state_nx;
  logic [WORD_LENGHT-1:0] shreg;
  logic [IW-1:0]          bit_idx;
  logic                   stop_cnt;
  logic                   par_en;
  logic                   par_bit;
  logic                   two_q;
  logic                   bit_tick;
  logic                   accept;
  logic                   last_data;
  logic                   last_stop;
  parity_mode_t           mode_in;

  assign mode_in = parity_mode_t'(parity_mode);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  assign last_data = bit_tick && (bit_idx == IW'(WORD_LENGHT - 1));
  // Ready during the final stop clock lets the next start bit follow with no gap.
  assign last_stop = (state == STOP) && bit_tick && (stop_cnt || !two_q);
  assign Tx_ready  = (state == IDLE) || last_stop;
  assign accept    = send && Tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    Tx_out   = 1'b1;
    case (state)
      IDLE: begin
        if (send) state_nx = START;
      end
      START: begin
        Tx_out = 1'b0;
        if (bit_tick) state_nx = DATA;
      end
      DATA: begin
        Tx_out = shreg[0];
        if (last_data) state_nx = par_en ? PARITY : STOP;
      end
      PARITY: begin
        Tx_out = par_bit;
        if (bit_tick) state_nx = STOP;
      end
      STOP: begin
        if (last_stop) state_nx = accept ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_q    <= 1'b0;
    end else if (accept) begin
      shreg    <= Tx_in;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= (mode_in == PAR_EVEN) || (mode_in == PAR_ODD);
      par_bit  <= (mode_in == PAR_ODD) ? ~^Tx_in : ^Tx_in;
      two_q    <= two_stop;
    end else if (bit_tick) begin
      case (state)
        DATA: begin
          shreg   <= {1'b0, shreg[WORD_LENGHT-1:1]};
          bit_idx <= bit_idx + IW'(1);
        end
        STOP:    stop_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter that serialises one parallel word per request into a standard asynchronous frame: start bit, data bits LSB first, an optional parity bit, and one or two stop bits. Each bit is held for a parametrised number of clocks by an internal baud counter. Parity mode and stop-bit count are selectable at run time. The block sits between the system-side producer and the serial pin, and is the drop-in successor of the fixed 8-bit, even-parity, one-clock-per-bit transmitter.

## Interface
Parameters:
- WORD_LENGHT, 8: data bits per frame, legal range 5..9.
- CLKS_PER_BIT, 16: clocks per serial bit, minimum 1.

Ports:
- clk  in  1  single system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- Tx_in  in  WORD_LENGHT  word to transmit.
- send  in  1  transmit request.
- parity_mode  in  2  2'b00 none, 2'b01 even, 2'b10 odd, 2'b11 reserved (treated as none).
- two_stop  in  1  0 selects one stop bit, 1 selects two.
- Tx_out  out  1  serial line, idle high.
- Tx_ready  out  1  high when a new request can be accepted.

## Operation
- Accept: the block accepts a request on any rising edge where send & Tx_ready is 1. At that edge it latches Tx_in, parity_mode and two_stop. Changes to any of these inputs during a frame are ignored.
- A request that arrives while Tx_ready is 0 is dropped. It is not queued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit time.
  - DATA lasts WORD_LENGHT bit times, sending bit index 0 first. It then goes to PARITY if the latched mode is even or odd, and to STOP otherwise.
  - PARITY -> STOP after one bit time.
  - STOP lasts 1 or 2 bit times. It then goes to START if send & Tx_ready (back-to-back) and to IDLE otherwise.
- Parity calculation:
  - even parity bit = ^data, so the total count of ones is even.
  - odd parity bit = ~^data.
- Tx_out values:
  - 1 in IDLE and STOP.
  - 0 in START.
  - data[bit_idx] in DATA.
  - the parity bit in PARITY.
- Tx_ready is 1 in IDLE and during the final clock of the last stop bit, so a back-to-back frame leaves no idle gap.
- Width rules:
  - The baud counter is CeilLog2(CLKS_PER_BIT) bits wide and wraps from CLKS_PER_BIT-1 to 0.
  - The bit index is CeilLog2(WORD_LENGHT) bits wide.
- Reset, asynchronous and at any point including mid-frame:
  - state = IDLE, counters = 0, shift data = 0.
  - Tx_out = 1 and Tx_ready = 1 immediately.
  - The interrupted frame is abandoned. There is no partial-frame recovery.

## Timing
- Accept edge is cycle 0. Tx_out drops to 0 and Tx_ready drops to 0 after that edge, with no extra latency.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length N = 1 + WORD_LENGHT + P + S bits, where P is 0 or 1 and S is 1 or 2. The frame lasts N*CLKS_PER_BIT cycles.
- Tx_ready rises in cycle N*CLKS_PER_BIT - 1, which is the last clock of the final stop bit.
- Back-to-back: an accept at that edge starts the next start bit in cycle N*CLKS_PER_BIT.
- Tx_out and Tx_ready are registered or state-decoded, and are glitch-free.
- With CLKS_PER_BIT = 1 the block sends one bit per clock. This matches the previous generation's cadence.

## Structure
- Shared package (Definitions): add CeilLog2 (already present) plus:
  - typedef enum logic [1:0] parity_mode_t {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD}
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
- Sub-module uart_baud_gen:
  - Parametrised by CLKS_PER_BIT, with clk, rst, a clear input and a bit_tick output.
  - bit_tick pulses on the last cycle of each bit. clear is asserted on accept.
  - The same sub-module is reused by the future RX.
- The top level holds the FSM, the data shift register, the bit index and the stop counter.

## Test plan
All scenarios use WORD_LENGHT=8 and CLKS_PER_BIT=4.
- Reset idle: assert rst, release, no send -> Tx_out=1 and Tx_ready=1 for 100 cycles.
- Even parity: Tx_in=8'hA5, mode 01, two_stop=0, one-cycle send -> Tx_out bits are 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit is held 4 cycles, 44 cycles total. Tx_ready is low in cycles 0..42 and high at cycle 43.
- Odd parity with two stop bits: Tx_in=8'hA5, mode 10, two_stop=1 -> parity bit 1, two stop bits, 48 cycles total.
- No parity and back-to-back: mode 00, send held high with Tx_in=8'h01 then 8'hFF -> two 10-bit frames. The second start bit begins at cycle 40 with no idle bit.
- Busy request dropped: send pulsed at cycle 10 with Tx_in=8'h3C during an 8'hA5 frame -> that frame completes unchanged and no 8'h3C frame follows.
- Reset mid-frame: assert rst at cycle 17 -> Tx_out=1 and Tx_ready=1 without waiting for a clock edge. A send after release starts a clean frame.
